// File: rtl/viterbi_ber_monitor.sv
// Post-decode BER monitor: delays each transmitted bit by the decoder latency,
// compares it with the decoded bit, and gathers error/burst/channel statistics per window.
module viterbi_ber_monitor #(
    parameter int DEC_LAT = 35,
    parameter int SKIP    = 8,
    parameter int WINDOW  = 256,
    parameter int CW      = 16,
    parameter int THRESH  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          tx_en_i,
    input  logic          tx_bit_i,
    input  logic          rx_bit_i,
    input  logic          chan_en_i,
    input  logic [1:0]    chan_tx_i,
    input  logic [1:0]    chan_rx_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          fail_o,
    output logic [CW-1:0] bit_ct_o,
    output logic [CW-1:0] err_ct_o,
    output logic [CW-1:0] chan_err_ct_o,
    output logic [CW-1:0] max_burst_o
);

    localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam int WW = $clog2(WINDOW + 1);
    localparam logic [SW-1:0] SKIP_END = SW'(SKIP);
    localparam logic [WW-1:0] WIN_END  = WW'(WINDOW);
    localparam logic [CW:0]   THRESH_W = (CW + 1)'(THRESH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_COUNT,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DEC_LAT-1:0] dly_en_q, dly_en_d;
    logic [DEC_LAT-1:0] dly_bit_q, dly_bit_d;

    logic [SW-1:0] skip_ct_q, skip_ct_d;
    logic [WW-1:0] win_ct_q, win_ct_d;
    logic [CW-1:0] bit_ct_q, bit_ct_d;
    logic [CW-1:0] err_ct_q, err_ct_d;
    logic [CW-1:0] chan_err_ct_q, chan_err_ct_d;
    logic [CW-1:0] max_burst_q, max_burst_d;
    logic [CW-1:0] run_ct_q, run_ct_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fail_q, fail_d;

    logic       cmp_v;
    logic       ref_bit;
    logic       mis;
    logic [1:0] chan_diff;
    logic [1:0] chan_pop;

    // Saturating add of a 0..3 increment; the extra carry bit detects overflow.
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + (CW + 1)'(b);
        return s[CW] ? {CW{1'b1}} : s[CW-1:0];
    endfunction

    always_comb begin
        dly_en_d  = (dly_en_q << 1) | DEC_LAT'(tx_en_i);
        dly_bit_d = (dly_bit_q << 1) | DEC_LAT'(tx_bit_i);
    end

    assign cmp_v     = dly_en_q[DEC_LAT-1];
    assign ref_bit   = dly_bit_q[DEC_LAT-1];
    assign mis       = cmp_v & (ref_bit ^ rx_bit_i);
    assign chan_diff = chan_tx_i ^ chan_rx_i;
    assign chan_pop  = {chan_diff[1] & chan_diff[0], chan_diff[1] ^ chan_diff[0]};

    always_comb begin
        state_d       = state_q;
        skip_ct_d     = skip_ct_q;
        win_ct_d      = win_ct_q;
        bit_ct_d      = bit_ct_q;
        err_ct_d      = err_ct_q;
        chan_err_ct_d = chan_err_ct_q;
        max_burst_d   = max_burst_q;
        run_ct_d      = run_ct_q;

        // A restart pulse overrides any compare or channel event in the same cycle.
        if (start_i) begin
            skip_ct_d     = '0;
            win_ct_d      = '0;
            bit_ct_d      = '0;
            err_ct_d      = '0;
            chan_err_ct_d = '0;
            max_burst_d   = '0;
            run_ct_d      = '0;
            state_d       = (SKIP == 0) ? ST_COUNT : ST_SKIP;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_SKIP: begin
                    if (cmp_v) begin
                        skip_ct_d = skip_ct_q + SW'(1);
                        if (skip_ct_d == SKIP_END) state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    if (cmp_v) begin
                        win_ct_d = win_ct_q + WW'(1);
                        bit_ct_d = sat_add(bit_ct_q, 2'd1);
                        err_ct_d = sat_add(err_ct_q, {1'b0, mis});
                        run_ct_d = mis ? sat_add(run_ct_q, 2'd1) : '0;
                        if (run_ct_d > max_burst_q) max_burst_d = run_ct_d;
                        if (win_ct_d == WIN_END) state_d = ST_DONE;
                    end
                    if (chan_en_i) chan_err_ct_d = sat_add(chan_err_ct_q, chan_pop);
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_SKIP) || (state_d == ST_COUNT);
        done_d = (state_d == ST_DONE);
        fail_d = done_d && ({1'b0, err_ct_d} > THRESH_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            dly_en_q      <= '0;
            dly_bit_q     <= '0;
            skip_ct_q     <= '0;
            win_ct_q      <= '0;
            bit_ct_q      <= '0;
            err_ct_q      <= '0;
            chan_err_ct_q <= '0;
            max_burst_q   <= '0;
            run_ct_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            dly_en_q      <= dly_en_d;
            dly_bit_q     <= dly_bit_d;
            skip_ct_q     <= skip_ct_d;
            win_ct_q      <= win_ct_d;
            bit_ct_q      <= bit_ct_d;
            err_ct_q      <= err_ct_d;
            chan_err_ct_q <= chan_err_ct_d;
            max_burst_q   <= max_burst_d;
            run_ct_q      <= run_ct_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fail_q        <= fail_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign fail_o        = fail_q;
    assign bit_ct_o      = bit_ct_q;
    assign err_ct_o      = err_ct_q;
    assign chan_err_ct_o = chan_err_ct_q;
    assign max_burst_o   = max_burst_q;

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// Directed bench for viterbi_ber_monitor: a 35-cycle delay stands in for the decoder,
// and errors are injected by compared-bit index with hand-derived expected totals.
module tb_viterbi_ber_monitor;

    localparam int DL    = 35;
    localparam int NSKIP = 8;
    localparam int WIN   = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic       tx_en_i;
    logic       tx_bit_i;
    logic       rx_bit_i;
    logic       chan_en_i;
    logic [1:0] chan_tx_i;
    logic [1:0] chan_rx_i;

    logic        busy_o, done_o, fail_o;
    logic [15:0] bit_ct_o, err_ct_o, chan_err_ct_o, max_burst_o;

    logic       sat_busy_o, sat_done_o, sat_fail_o;
    logic [3:0] sat_bit_ct_o, sat_err_ct_o, sat_chan_err_ct_o, sat_max_burst_o;

    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   meas_k = 0;
    int   err_mode  = 0;
    int   chan_mode = 0;
    logic force_err = 1'b0;
    logic sat_early;
    logic hist_en  [DL];
    logic hist_bit [DL];

    viterbi_ber_monitor dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .tx_en_i(tx_en_i), .tx_bit_i(tx_bit_i), .rx_bit_i(rx_bit_i),
        .chan_en_i(chan_en_i), .chan_tx_i(chan_tx_i), .chan_rx_i(chan_rx_i),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
        .bit_ct_o(bit_ct_o), .err_ct_o(err_ct_o),
        .chan_err_ct_o(chan_err_ct_o), .max_burst_o(max_burst_o)
    );

    viterbi_ber_monitor #(.CW(4)) dut_sat (
        .clk(clk), .rst(rst), .start_i(start_i),
        .tx_en_i(tx_en_i), .tx_bit_i(tx_bit_i), .rx_bit_i(rx_bit_i),
        .chan_en_i(chan_en_i), .chan_tx_i(chan_tx_i), .chan_rx_i(chan_rx_i),
        .busy_o(sat_busy_o), .done_o(sat_done_o), .fail_o(sat_fail_o),
        .bit_ct_o(sat_bit_ct_o), .err_ct_o(sat_err_ct_o),
        .chan_err_ct_o(sat_chan_err_ct_o), .max_burst_o(sat_max_burst_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkCounts(input string tag, input int b, input int e, input int c, input int m);
        checkOutput({tag, " bit_ct"}, 32'(bit_ct_o), b);
        checkOutput({tag, " err_ct"}, 32'(err_ct_o), e);
        checkOutput({tag, " chan_err_ct"}, 32'(chan_err_ct_o), c);
        checkOutput({tag, " max_burst"}, 32'(max_burst_o), m);
    endtask

    // One clock: drive inputs, let the edge pass, then advance the decoder model.
    task automatic applyStimulus(input logic start_v, input logic rst_v);
        logic cmp, inv, flip;
        int   cidx;
        cmp  = hist_en[DL-1];
        cidx = meas_k - NSKIP;
        inv  = 1'b0;
        if (cmp) begin
            case (err_mode)
                1: inv = (cidx == 10) || (cidx == 50) || (cidx == 51);
                2: inv = (meas_k < NSKIP);
                3: inv = 1'b1;
                4: inv = (cidx >= 80) && (cidx <= 85);
                default: inv = 1'b0;
            endcase
            if (force_err) inv = 1'b1;
        end
        flip = cmp && (force_err || ((chan_mode == 1) &&
               ((cidx == 20) || (cidx == 30) || (cidx == 40) || (cidx == 50) || (cidx == 60))));
        rst       = rst_v;
        start_i   = start_v;
        tx_en_i   = ((cyc % 7) != 3);
        tx_bit_i  = 1'($urandom);
        rx_bit_i  = hist_bit[DL-1] ^ inv;
        chan_en_i = 1'b1;
        chan_tx_i = 2'($urandom);
        chan_rx_i = flip ? ~chan_tx_i : chan_tx_i;
        @(posedge clk);
        #1;
        if (rst_v) begin
            for (int i = 0; i < DL; i++) begin
                hist_en[i]  = 1'b0;
                hist_bit[i] = 1'b0;
            end
        end else begin
            for (int i = DL - 1; i > 0; i--) begin
                hist_en[i]  = hist_en[i-1];
                hist_bit[i] = hist_bit[i-1];
            end
            hist_en[0]  = tx_en_i;
            hist_bit[0] = tx_bit_i;
        end
        if (start_v) meas_k = 0;
        else if (cmp) meas_k++;
        cyc++;
    endtask

    task automatic startMeasurement(input string tag);
        applyStimulus(1'b1, 1'b0);
        checkOutput({tag, " busy after start"}, 32'(busy_o), 1);
        checkOutput({tag, " done after start"}, 32'(done_o), 0);
    endtask

    task automatic runToDone(input string tag);
        int n;
        n = 0;
        sat_early = 1'b0;
        while (!done_o && n < 3000) begin
            applyStimulus(1'b0, 1'b0);
            if (!done_o && sat_done_o) sat_early = 1'b1;
            n++;
        end
        checkOutput({tag, " done"}, 32'(done_o), 1);
        checkOutput({tag, " compared bits at done"}, meas_k, NSKIP + WIN);
        checkOutput({tag, " busy at done"}, 32'(busy_o), 0);
        checkOutput({tag, " sat done early"}, 32'(sat_early), 0);
    endtask

    task automatic runToBit(input string tag, input int k);
        int n;
        n = 0;
        while (!(meas_k >= k && hist_en[DL-1]) && n < 2000) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        checkOutput({tag, " reached bit"}, meas_k, k);
    endtask

    initial begin
        for (int i = 0; i < DL; i++) begin
            hist_en[i]  = 1'b0;
            hist_bit[i] = 1'b0;
        end
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("reset busy", 32'(busy_o), 0);
        checkOutput("reset done", 32'(done_o), 0);
        checkOutput("reset fail", 32'(fail_o), 0);
        checkCounts("reset", 0, 0, 0, 0);

        $display("[TB] clean run");
        startMeasurement("clean");
        runToDone("clean");
        checkCounts("clean", 256, 0, 0, 0);
        checkOutput("clean fail", 32'(fail_o), 0);

        $display("[TB] sparse errors");
        err_mode = 1; chan_mode = 1;
        startMeasurement("sparse");
        runToDone("sparse");
        checkCounts("sparse", 256, 3, 10, 2);
        checkOutput("sparse fail", 32'(fail_o), 1);
        err_mode = 3; force_err = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);
        force_err = 1'b0;
        checkOutput("done held", 32'(done_o), 1);
        checkCounts("done frozen", 256, 3, 10, 2);

        $display("[TB] skip region");
        err_mode = 2; chan_mode = 0;
        startMeasurement("skip");
        runToDone("skip");
        checkCounts("skip", 256, 0, 0, 0);
        checkOutput("skip fail", 32'(fail_o), 0);

        $display("[TB] saturation");
        err_mode = 3;
        startMeasurement("sat");
        runToDone("sat");
        checkOutput("sat cw4 done", 32'(sat_done_o), 1);
        checkOutput("sat cw4 bit_ct", 32'(sat_bit_ct_o), 15);
        checkOutput("sat cw4 err_ct", 32'(sat_err_ct_o), 15);
        checkOutput("sat cw4 max_burst", 32'(sat_max_burst_o), 15);
        checkOutput("sat cw4 fail", 32'(sat_fail_o), 1);
        checkCounts("sat cw16", 256, 256, 0, 256);
        checkOutput("sat cw16 fail", 32'(fail_o), 1);

        $display("[TB] restart mid-count");
        err_mode = 4; chan_mode = 1;
        startMeasurement("restart");
        runToBit("restart", 100);
        checkCounts("before restart", 92, 6, 10, 6);
        force_err = 1'b1;
        applyStimulus(1'b1, 1'b0);
        force_err = 1'b0; err_mode = 0; chan_mode = 0;
        checkCounts("after restart", 0, 0, 0, 0);
        checkOutput("after restart busy", 32'(busy_o), 1);
        checkOutput("after restart done", 32'(done_o), 0);
        runToDone("restart");
        checkCounts("restart final", 256, 0, 0, 0);

        $display("[TB] reset mid-count");
        err_mode = 3;
        startMeasurement("rstmid");
        runToBit("rstmid", 100);
        applyStimulus(1'b0, 1'b1);
        checkOutput("rstmid busy", 32'(busy_o), 0);
        checkOutput("rstmid done", 32'(done_o), 0);
        checkOutput("rstmid fail", 32'(fail_o), 0);
        checkCounts("rstmid", 0, 0, 0, 0);
        err_mode = 0;
        startMeasurement("post-reset");
        runToDone("post-reset");
        checkCounts("post-reset", 256, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
